// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_pkg
//  Purpose  : Shared types and defaults for the sequential binary-to-BCD
//             converter (digit type, FSM state encoding, default sizes).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  localparam int BCD_WIDTH  = 11;
  localparam int BCD_DIGITS = 4;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  // 10**exp as a 64-bit value, used to check that the digit count can hold
  // the largest binary input.
  function automatic longint pow10(input int exp);
    longint r;
    r = 1;
    for (int i = 0; i < exp; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_add3
//  Purpose  : Double-dabble digit correction. Adds 3 to a BCD digit that is
//             5 or more so that the following left shift carries correctly
//             into the next decimal digit.
//  Ports    : in_i  - BCD digit before correction
//             out_o - corrected digit (4-bit result, no carry out)
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t in_i,
  output bcd_digit_t out_o
);

  assign out_o = (in_i >= 4'd5) ? (in_i + 4'd3) : in_i;

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bin_to_bcd_seq
//  Purpose  : Sequential binary-to-BCD converter (shift-and-add-3), one
//             binary bit per clock, start/busy/done handshake.
//  Ports    : clk    - clock, rising edge
//             rst    - synchronous active-high reset
//             start  - conversion request, sampled only while idle
//             value  - binary operand, captured on the accepted start edge
//             busy   - high while a conversion or its done cycle is active
//             done   - one-cycle pulse, d3..d0 freshly updated
//             d3..d0 - thousands, hundreds, tens, units digits
//  Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = BCD_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [3:0]       d3,
  output logic [3:0]       d2,
  output logic [3:0]       d1,
  output logic [3:0]       d0
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Reject configurations whose decimal range cannot hold 2**WIDTH-1, and
  // configurations that do not match the fixed four-digit output port set.
  if (!(pow10(DIGITS) > ((longint'(1) << WIDTH) - 1))) begin : g_bad_range
    $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
  end
  if (DIGITS != 4) begin : g_bad_digits
    $error("bin_to_bcd_seq: output ports carry exactly four digits");
  end

  conv_state_t      state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;      // {BCD field, binary field}
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] dig_q, dig_d;

  logic [BCD_W-1:0] bcd_adj;
  logic [SR_W-1:0]  sr_adj;
  logic [SR_W-1:0]  sr_shift;

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .in_i  (sr_q[WIDTH + 4*i +: 4]),
      .out_o (bcd_adj[4*i +: 4])
    );
  end

  // Correct every digit first, then shift the whole register left by one.
  assign sr_adj   = {bcd_adj, sr_q[WIDTH-1:0]};
  assign sr_shift = sr_adj << 1;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {{BCD_W{1'b0}}, value};
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + 1'b1;
        // This edge performs the final (WIDTH-th) shift.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          dig_d   = sr_shift[SR_W-1 -: BCD_W];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign d3   = dig_q[12 +: 4];
  assign d2   = dig_q[8  +: 4];
  assign d1   = dig_q[4  +: 4];
  assign d0   = dig_q[0  +: 4];

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin_to_bcd_seq
//  Purpose  : Self-checking bench for bin_to_bcd_seq. A cycle-level
//             behavioural model (remaining-cycle count plus decimal
//             arithmetic) is compared against the DUT every cycle; directed
//             tests add hand-computed digit and timing expectations.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;
  import bcd_pkg::*;

  localparam int W = BCD_WIDTH;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] value = '0;
  logic         busy;
  logic         done;
  logic [3:0]   d3, d2, d1, d0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(BCD_DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (done),
    .d3    (d3),
    .d2    (d2),
    .d1    (d1),
    .d0    (d0)
  );

  function automatic logic [15:0] dec4(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // m_left: clock edges remaining until the block is idle again.
  int          m_left  = 0;
  int          m_val   = 0;
  logic [15:0] m_dig   = '0;
  bit          m_valid = 1'b0;

  always begin
    @(posedge clk);
    if (rst) begin
      m_left  = 0;
      m_dig   = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_left == 0) begin
        if (start) begin
          m_left = W + 1;
          m_val  = int'(value);
        end
      end else begin
        m_left--;
        if (m_left == 1) m_dig = dec4(m_val);
      end
    end
    #1;
    if (m_valid) begin
      check("cyc_busy",   {15'b0, busy}, {15'b0, (m_left != 0)});
      check("cyc_done",   {15'b0, done}, {15'b0, (m_left == 1)});
      check("cyc_digits", {d3, d2, d1, d0}, m_dig);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic run_conv(input int v, output logic [15:0] dig, output int lat,
                          output int busy_cycles);
    @(negedge clk);
    start = 1'b1;
    value = W'(v);
    lat = 0;
    busy_cycles = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (busy) busy_cycles++;
      if (done) begin
        lat = n;
        break;
      end
    end
    dig = {d3, d2, d1, d0};
    if (lat == 0) begin
      checks++;
      failures++;
      $display("FAIL conv_timeout value=%0d: actual=no_done required=done", v);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [15:0] dig;
    int lat, bc, ndone, first_n, gap;
    int          vals [3] = '{999, 1000, 2047};
    logic [15:0] exps [3] = '{16'h0999, 16'h1000, 16'h2047};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", {15'b0, busy}, 16'h0);
    check("reset_done", {15'b0, done}, 16'h0);
    check("reset_digits", {d3, d2, d1, d0}, 16'h0000);

    // value 0: latency and busy width
    run_conv(0, dig, lat, bc);
    check("zero_digits", dig, 16'h0000);
    check("zero_latency", 16'(lat), 16'(W + 1));
    check("zero_busy_cycles", 16'(bc), 16'd12);
    @(negedge clk);
    check("zero_done_width", {15'b0, done}, 16'h0);
    check("zero_idle", {15'b0, busy}, 16'h0);

    // boundary values
    for (int i = 0; i < 3; i++) begin
      run_conv(vals[i], dig, lat, bc);
      check("dir_digits", dig, exps[i]);
      check("dir_latency", 16'(lat), 16'd12);
      @(negedge clk);
      check("dir_done_width", {15'b0, done}, 16'h0);
    end

    // start while busy is ignored
    @(negedge clk);
    start = 1'b1;
    value = W'(123);
    ndone = 0;
    first_n = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 5) begin
        start = 1'b1;
        value = W'(456);
      end
      if (n == 6) start = 1'b0;
      if (done) begin
        ndone++;
        if (first_n == 0) first_n = n;
      end
    end
    check("busy_start_done_count", 16'(ndone), 16'd1);
    check("busy_start_latency", 16'(first_n), 16'd12);
    check("busy_start_digits", {d3, d2, d1, d0}, 16'h0123);

    // start held high, value toggling
    @(negedge clk);
    start = 1'b1;
    value = W'(42);
    first_n = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done) begin
        first_n = n;
        break;
      end
    end
    check("held_first_latency", 16'(first_n), 16'd12);
    check("held_first_digits", {d3, d2, d1, d0}, 16'h0042);
    value = W'(1999);
    gap = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done) begin
        gap = n;
        break;
      end
      check("held_stable_digits", {d3, d2, d1, d0}, 16'h0042);
    end
    start = 1'b0;
    check("held_period", 16'(gap), 16'd13);
    check("held_second_digits", {d3, d2, d1, d0}, 16'h1999);
    @(negedge clk);

    // reset during a conversion
    @(negedge clk);
    start = 1'b1;
    value = W'(777);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 6) rst = 1'b1;
    end
    @(negedge clk);
    check("midrst_busy", {15'b0, busy}, 16'h0);
    check("midrst_done", {15'b0, done}, 16'h0);
    check("midrst_digits", {d3, d2, d1, d0}, 16'h0000);
    rst = 1'b0;
    ndone = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", 16'(ndone), 16'd0);
    run_conv(5, dig, lat, bc);
    check("midrst_fresh_digits", dig, 16'h0005);

    // exhaustive sweep against decimal arithmetic
    for (int v = 0; v < (1 << W); v++) begin
      run_conv(v, dig, lat, bc);
      check("sweep_digits", dig, dec4(v));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble). It turns an 11-bit binary value into four packed BCD digits for display and keypad-echo paths. The block sits downstream of the BCD-to-binary accumulation logic and hands digits back to the 7-segment and digit-multiplex logic. It converts one bit per clock under a start/busy/done handshake.

Parameters:
WIDTH, 11, binary input width; one conversion iteration per bit.
DIGITS, 4, BCD output digits; must satisfy 10**DIGITS > 2**WIDTH - 1. Elaboration fails otherwise.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a conversion; sampled only in IDLE.
value  input  WIDTH  binary operand; captured on the accepted start edge only.
busy  output  1  high while state != IDLE.
done  output  1  one-cycle pulse; the digits are valid and newly updated.
d3  output  4  thousands digit.
d2  output  4  hundreds digit.
d1  output  4  tens digit.
d0  output  4  units digit.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset, checked at each clk edge with priority over everything else:
  - state=IDLE, busy=0, done=0, d3..d0=0.
  - Shift register and iteration counter cleared.
- States: IDLE, CONV, DONE.
- IDLE:
  - start=1 at edge k: load value into the binary shift field, clear the BCD field, counter=0, go to CONV.
  - start=0: stay in IDLE.
- CONV, at each edge, in this order:
  - For every BCD digit >= 5, add 3 (4-bit add, no carry into the next digit).
  - Shift the concatenated {BCD field, binary field} left by 1.
  - Increment the counter.
  - When counter reaches WIDTH-1 at this edge (the WIDTH-th shift, edge k+WIDTH): register the post-shift BCD field into d3..d0 and go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Next edge returns to IDLE.
- Latency: start accepted at edge k; done high in the cycle after edge k+WIDTH (11 cycles for the default). A new start is accepted no earlier than edge k+WIDTH+2.
- busy = 1 in CONV and DONE.
- start while busy (CONV or DONE) is ignored: no queuing, no restart. value is don't-care outside the accepting edge.
- d3..d0 hold their last result between conversions. They change only on entry to DONE or on reset.
- Width rules:
  - Internal shift register is 4*DIGITS+WIDTH bits.
  - Maximum input 2**WIDTH-1 = 2047 gives 2,0,4,7.
  - No saturation; every input is representable.
- Reset mid-CONV: the conversion is aborted, no done pulse is produced, and the outputs go to 0.
- start held high continuously: one conversion per WIDTH+2 cycles, value sampled at each IDLE edge.

Decomposition:
- Package bcd_pkg holds:
  - localparams BCD_WIDTH=11 and BCD_DIGITS=4;
  - typedef bcd_digit_t (logic [3:0]);
  - enum conv_state_t {IDLE, CONV, DONE}.
- One sub-module, bcd_add3: combinational 4-bit digit correction (in >= 5 ? in+3 : in). It is instantiated DIGITS times via generate.
- The FSM, counter and shift register stay in bin_to_bcd_seq.

Test Plan:
- Reset, then start with value=0 -> done after 11 cycles; d3..d0=0,0,0,0; busy high for 12 cycles total.
- value=999 -> 0,9,9,9; value=1000 -> 1,0,0,0; value=2047 -> 2,0,4,7. Check done is exactly one cycle wide, at cycle k+WIDTH+1.
- start with value=123, then pulse start with value=456 at cycle k+5 -> single done; result 0,1,2,3; no second done.
- start held high with value toggling 42/1999 -> conversions every 13 cycles giving 0,0,4,2 then 1,9,9,9; the digits stay stable between done pulses.
- Assert rst at cycle k+6 of a conversion of value=777 -> next cycle busy=0, done=0, digits=0. No done pulse follows, and a fresh start with 5 yields 0,0,0,5.
- Exhaustive sweep 0..2047 against a reference model (value/1000, /100%10, /10%10, %10) -> every result matches.
